keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per scan tick, legal range >= 2.
REQ-002 Parameter DEB_CNT, default 8: consecutive identical tick samples needed to accept a press or a release, legal range >= 2.
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 col_in  input  4  keypad column sense, active-low, externally pulled up.
REQ-006 row_out  output  4  keypad row drive, one-hot active-low, registered.
REQ-007 key_code  output  4  code of the last accepted key, equal to row_index*4 + col_index, registered.
REQ-008 key_valid  output  1  one-clock pulse when a new key is accepted.
REQ-009 key_held  output  1  level; high while the accepted key remains pressed.

Function
REQ-010 The block SHALL contain a prescaler that counts 0..SCAN_DIV-1 and wraps to 0; tick is the cycle in which the count equals SCAN_DIV-1.
REQ-011 The block SHALL sample col_in only on tick cycles.
REQ-012 The block SHALL implement three states, SCAN, DEBOUNCE and HELD, and SHALL take all transitions on tick cycles only.
REQ-013 In SCAN, when all sampled columns are high, row_out SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110 on each tick.
REQ-014 In SCAN, when any sampled column is low:
 - row_out SHALL hold its current value.
 - The block SHALL latch the lowest low column index as the candidate.
 - The candidate code SHALL be row_index*4 + col_index.
 - The debounce count SHALL be set to 1.
 - The state SHALL change to DEBOUNCE.
REQ-015 In DEBOUNCE, on each tick:
 - Candidate column low: the debounce count SHALL increment.
 - Candidate column high: the block SHALL return to SCAN and rotate row_out to the next row on that same tick, with no key_valid.
 - Other columns SHALL be ignored.
REQ-016 When the debounce count reaches DEB_CNT:
 - key_code SHALL load the candidate code.
 - key_valid SHALL be high for exactly the following clock.
 - key_held SHALL rise in that same clock.
 - The state SHALL change to HELD.
REQ-017 In HELD, row_out SHALL stay frozen.
REQ-018 In HELD, each tick with the candidate column high SHALL increment a release count, and each tick with it low SHALL clear the release count to 0.
REQ-019 When the release count reaches DEB_CNT:
 - key_held SHALL fall.
 - Both counts SHALL clear.
 - The state SHALL change to SCAN.
 - row_out SHALL rotate to the next row.
REQ-020 key_valid SHALL pulse at most once per accepted press; holding a key SHALL NOT repeat the pulse.
REQ-021 key_code SHALL keep its value until the next accepted press.
REQ-022 The debounce and release counters SHALL be wide enough to hold DEB_CNT without wrap-around.
REQ-023 With a clean press present at the capture tick, key_valid SHALL assert exactly (DEB_CNT-1)*SCAN_DIV + 1 clocks after the capture tick.
REQ-024 If a reset assertion occurs in any state, the block SHALL abort that state without emitting key_valid.

Reset
REQ-025 While rst is low, the block SHALL force:
 - row_out = 4'b1110
 - key_code = 4'h0, key_valid = 0, key_held = 0
 - state = SCAN
 - prescaler, debounce count and release count = 0
REQ-026 After rst is released, the first tick SHALL occur SCAN_DIV clocks later.

Verification (SCAN_DIV=4, DEB_CNT=3)
REQ-027 Reset, then idle columns (4'b1111) -> row_out steps 1110, 1101, 1011, 0111, 1110 every 4 clocks; key_valid never asserts.
REQ-028 col_in = 4'b1101 held whenever row_out = 1011 -> state freezes at 1011; 9 clocks after the capture tick, key_valid pulses once with key_code = 9; key_held = 1.
REQ-029 Bounce: col_in[0] low for one tick on row 0111, then high -> no key_valid; row_out moves to 1110 on the next tick.
REQ-030 Two columns low (4'b0101) on row 1110 -> key_code = 1 after debounce; col 3 ignored.
REQ-031 Release from HELD: col high, low, then high for 3 ticks -> key_held falls only after the third consecutive high tick; scanning resumes at the next row.
REQ-032 rst pulled low mid-DEBOUNCE -> all outputs return to reset values immediately; no key_valid; scanning restarts from 1110.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, debounces a press on
// the scan tick, and reports the accepted key code with a one-clock valid pulse.
module keypad_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEB_CNT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEB,
    S_HELD
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ps;
  logic [CW-1:0]   r_deb;
  logic [CW-1:0]   r_rel;
  logic [1:0]      r_cand_col;
  logic [3:0]      r_cand_code;

  logic            w_tick;
  logic            w_col_any;
  logic [1:0]      w_col_idx;
  logic [1:0]      w_row_idx;
  logic            w_cand_low;
  logic [3:0]      w_row_next;

  assign w_tick     = (r_ps == PS_LAST);
  assign w_col_any  = ~&col_in;
  assign w_cand_low = ~col_in[r_cand_col];
  assign w_row_next = {row_out[2:0], row_out[3]};

  // Lowest-numbered low column wins when several are pressed in one row.
  always_comb begin
    w_col_idx = 2'd0;
    if (!col_in[0])      w_col_idx = 2'd0;
    else if (!col_in[1]) w_col_idx = 2'd1;
    else if (!col_in[2]) w_col_idx = 2'd2;
    else if (!col_in[3]) w_col_idx = 2'd3;
  end

  always_comb begin
    w_row_idx = 2'd0;
    case (row_out)
      4'b1101: w_row_idx = 2'd1;
      4'b1011: w_row_idx = 2'd2;
      4'b0111: w_row_idx = 2'd3;
      default: w_row_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ps <= '0;
    end else if (w_tick) begin
      r_ps <= '0;
    end else begin
      r_ps <= r_ps + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_SCAN;
      row_out     <= 4'b1110;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      r_deb       <= '0;
      r_rel       <= '0;
      r_cand_col  <= 2'd0;
      r_cand_code <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_col_any) begin
              r_cand_col  <= w_col_idx;
              r_cand_code <= {w_row_idx, w_col_idx};
              r_deb       <= CW'(1);
              r_state     <= S_DEB;
            end else begin
              row_out <= w_row_next;
            end
          end
          S_DEB: begin
            if (w_cand_low) begin
              if (r_deb == CNT_LAST) begin
                key_code  <= r_cand_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                r_deb     <= '0;
                r_rel     <= '0;
                r_state   <= S_HELD;
              end else begin
                r_deb <= r_deb + CW'(1);
              end
            end else begin
              // Bounce: give up and keep scanning from the next row.
              r_deb   <= '0;
              row_out <= w_row_next;
              r_state <= S_SCAN;
            end
          end
          S_HELD: begin
            if (w_cand_low) begin
              r_rel <= '0;
            end else if (r_rel == CNT_LAST) begin
              key_held <= 1'b0;
              r_rel    <= '0;
              r_deb    <= '0;
              row_out  <= w_row_next;
              r_state  <= S_SCAN;
            end else begin
              r_rel <= r_rel + CW'(1);
            end
          end
          default: begin
            r_state <= S_SCAN;
            row_out <= 4'b1110;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a small keypad matrix model driving col_in.
module tb_keypad_scan;

  logic       clk;
  logic       rst;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  int          total;
  int          bad;
  int          valid_cnt;

  keypad_scan #(.SCAN_DIV(4), .DEB_CNT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed switch at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (key_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    valid_cnt = 0;
    pressed   = '0;
    rst       = 1'b0;
    step(3);
    check("rst_row", 16'(row_out), 16'h000E);
    check("rst_code", 16'(key_code), 16'h0);
    check("rst_valid", 16'(key_valid), 16'h0);
    check("rst_held", 16'(key_held), 16'h0);
    rst = 1'b1;

    // Idle rotation, one row per 4 clocks
    step(3);
    check("first_tick_not_yet", 16'(row_out), 16'h000E);
    step(1);
    check("idle_row1", 16'(row_out), 16'h000D);
    step(4);
    check("idle_row2", 16'(row_out), 16'h000B);
    step(4);
    check("idle_row3", 16'(row_out), 16'h0007);
    step(4);
    check("idle_row0", 16'(row_out), 16'h000E);
    check("idle_no_valid", 16'(valid_cnt), 16'd0);

    // Press key 9 (row 2, col 1); capture at tick 28, valid in cycle 37
    pressed = 16'h0200;
    step(4);
    check("k9_row1", 16'(row_out), 16'h000D);
    step(4);
    check("k9_row2", 16'(row_out), 16'h000B);
    step(4);
    check("k9_frozen", 16'(row_out), 16'h000B);
    step(7);
    check("k9_valid_early", 16'(key_valid), 16'h0);
    step(1);
    check("k9_valid", 16'(key_valid), 16'h1);
    check("k9_code", 16'(key_code), 16'd9);
    check("k9_held", 16'(key_held), 16'h1);
    step(1);
    check("k9_valid_once", 16'(key_valid), 16'h0);
    check("k9_held_on", 16'(key_held), 16'h1);

    // Release: high (tick 40), low (tick 44), high x3 (48,52,56)
    pressed = '0;
    step(3);
    pressed = 16'h0200;
    step(4);
    pressed = '0;
    step(8);
    check("rel_held_2", 16'(key_held), 16'h1);
    check("rel_row_frozen", 16'(row_out), 16'h000B);
    step(4);
    check("rel_held_off", 16'(key_held), 16'h0);
    check("rel_row_next", 16'(row_out), 16'h0007);
    check("rel_code_kept", 16'(key_code), 16'd9);
    check("rel_no_repeat", 16'(valid_cnt), 16'd1);

    // Bounce on row 3 col 0: low at tick 60, high at tick 64
    pressed = 16'h1000;
    step(4);
    check("bnc_frozen", 16'(row_out), 16'h0007);
    pressed = '0;
    step(4);
    check("bnc_row_next", 16'(row_out), 16'h000E);
    check("bnc_held", 16'(key_held), 16'h0);
    step(4);
    check("bnc_scan", 16'(row_out), 16'h000D);
    check("bnc_no_valid", 16'(valid_cnt), 16'd1);

    // Keys 1 and 3 on row 0: capture at tick 84 picks col 1; col 3 dropped during debounce
    pressed = 16'h000A;
    step(16);
    check("two_frozen", 16'(row_out), 16'h000E);
    pressed = 16'h0002;
    step(8);
    check("two_valid", 16'(key_valid), 16'h1);
    check("two_code", 16'(key_code), 16'd1);
    check("two_held", 16'(key_held), 16'h1);
    pressed = '0;
    step(12);
    check("two_rel", 16'(key_held), 16'h0);
    check("two_row_next", 16'(row_out), 16'h000D);
    check("two_cnt", 16'(valid_cnt), 16'd2);

    // Key 5 on row 1: capture at tick 108, reset two clocks later
    pressed = 16'h0020;
    step(4);
    check("rd_frozen", 16'(row_out), 16'h000D);
    step(2);
    rst = 1'b0;
    #1;
    check("rd_row", 16'(row_out), 16'h000E);
    check("rd_code", 16'(key_code), 16'h0);
    check("rd_valid", 16'(key_valid), 16'h0);
    check("rd_held", 16'(key_held), 16'h0);
    step(3);
    pressed = '0;
    rst = 1'b1;
    step(3);
    check("rd_wait", 16'(row_out), 16'h000E);
    step(1);
    check("rd_restart", 16'(row_out), 16'h000D);
    step(8);
    check("rd_no_valid", 16'(valid_cnt), 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
